// File: rtl/fp_div_normround_if.sv
// rtl/fp_div_normround_if.sv - handshake bundle between divider core, normalize/round stage and consumer
//
// Purpose: groups the upstream result handshake (in_*) and the downstream
// packed-result handshake (out_valid/out_ready/Out) of fp_div_normround.
// Ports (signals):
//   in_valid/in_ready   upstream handshake, transfer when both high
//   in_sign             result sign
//   in_exp              signed biased exponent, EXP_W bits two's complement
//   in_mant             quotient mantissa, [MANT_W-1] = 2^0
//   in_sticky           remainder nonzero
//   in_special          00 normal, 01 zero, 10 infinity, 11 NaN
//   out_valid/out_ready downstream handshake
//   Out                 packed IEEE-754 single
// Modports: slave = the stage itself, master = whoever drives and consumes it.
interface fp_div_normround_if #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 27
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              in_sticky;
  logic [1:0]        in_special;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       Out;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_sticky, in_special, out_ready,
    output in_ready, out_valid, Out
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_sticky, in_special, out_ready,
    input  in_ready, out_valid, Out
  );
endinterface

// File: rtl/fp_div_normround.sv
// rtl/fp_div_normround.sv - post-divide normalize, denormalize, round-to-nearest-even and pack stage
//
// Purpose: takes the raw quotient (sign, unbounded signed biased exponent,
// MANT_W-bit mantissa, sticky) from the divider core, normalizes it one bit
// per cycle, shifts subnormals right one bit per cycle, rounds to nearest
// even, clamps overflow to infinity and emits a packed IEEE-754 single.
// One operation in flight at a time.
// Ports:
//   int_clk  single clock, rising edge
//   reset    asynchronous, active-high; forces IDLE, clears Out/out_valid
//   bus      fp_div_normround_if.slave: in_* upstream handshake and data,
//            out_valid/out_ready/Out downstream handshake and result
module fp_div_normround #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 27
) (
  input  logic               int_clk,
  input  logic               reset,
  fp_div_normround_if.slave  bus
);

  // Fraction bits of the packed result: mantissa minus hidden bit, guard and two round bits.
  localparam int FRAC_W = MANT_W - 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NORM   = 3'd1;
  localparam logic [2:0] S_DENORM = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic signed [EXP_W-1:0] EXP_ZERO  = EXP_W'(0);
  localparam logic signed [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_FLUSH = EXP_W'(-26);
  localparam logic signed [EXP_W-1:0] EXP_MAX   = EXP_W'(255);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic [2:0]               state;
  logic                     sign_q;
  logic signed [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0]        mant_q;
  logic                     sticky_q;
  logic                     first_q;      // first cycle spent in DENORM
  logic [31:0]              out_q;
  logic                     out_valid_q;

  // Rounding datapath, only consumed in ROUND.
  logic                     rnd_lsb;
  logic                     rnd_guard;
  logic                     rnd_rest;
  logic                     rnd_inc;
  logic [MANT_W-3:0]        rnd_sum;      // one extra bit to catch the carry out of the hidden bit
  logic                     rnd_carry;
  logic                     rnd_hidden;
  logic [FRAC_W-1:0]        rnd_frac;
  logic signed [EXP_W-1:0]  rnd_exp;
  logic [31:0]              rnd_word;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.Out       = out_q;

  always_comb begin
    rnd_lsb    = mant_q[3];
    rnd_guard  = mant_q[2];
    rnd_rest   = mant_q[1] | mant_q[0] | sticky_q;
    rnd_inc    = rnd_guard & (rnd_rest | rnd_lsb);
    rnd_sum    = {1'b0, mant_q[MANT_W-1:3]} + {{(MANT_W-3){1'b0}}, rnd_inc};
    rnd_carry  = rnd_sum[MANT_W-3];
    // A carry out leaves the mantissa at exactly 1.0 with the exponent bumped.
    rnd_hidden = rnd_carry | rnd_sum[MANT_W-4];
    rnd_frac   = rnd_carry ? '0 : rnd_sum[FRAC_W-1:0];
    rnd_exp    = rnd_carry ? (exp_q + EXP_ONE) : exp_q;
    if (rnd_exp >= EXP_MAX) begin
      rnd_word = {sign_q, 8'hFF, 23'h0};
    end else begin
      // Subnormals sit at exp=1 with the hidden bit clear, so they pack with a
      // zero exponent field; one that rounds up into the hidden bit packs as 1.
      rnd_word = {sign_q, (rnd_hidden ? rnd_exp[7:0] : 8'h00), rnd_frac};
    end
  end

  always_ff @(posedge int_clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      sign_q      <= 1'b0;
      exp_q       <= EXP_ZERO;
      mant_q      <= '0;
      sticky_q    <= 1'b0;
      first_q     <= 1'b0;
      out_q       <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sign_q   <= bus.in_sign;
            exp_q    <= bus.in_exp;
            mant_q   <= bus.in_mant;
            sticky_q <= bus.in_sticky;
            case (bus.in_special)
              2'b01: begin
                out_q       <= {bus.in_sign, 31'h0};
                out_valid_q <= 1'b1;
                state       <= S_DONE;
              end
              2'b10: begin
                out_q       <= {bus.in_sign, 8'hFF, 23'h0};
                out_valid_q <= 1'b1;
                state       <= S_DONE;
              end
              2'b11: begin
                out_q       <= QNAN;
                out_valid_q <= 1'b1;
                state       <= S_DONE;
              end
              default: state <= S_NORM;
            endcase
          end
        end

        S_NORM: begin
          if (mant_q == '0) begin
            out_q       <= {sign_q, 31'h0};
            out_valid_q <= 1'b1;
            state       <= S_DONE;
          end else if (!mant_q[MANT_W-1]) begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end else if (exp_q < EXP_ONE) begin
            first_q <= 1'b1;
            state   <= S_DENORM;
          end else begin
            state <= S_ROUND;
          end
        end

        S_DENORM: begin
          first_q <= 1'b0;
          if (first_q && (exp_q < EXP_FLUSH)) begin
            // Too small to keep any mantissa bit: everything becomes sticky.
            mant_q   <= '0;
            sticky_q <= 1'b1;
            exp_q    <= EXP_ONE;
            state    <= S_ROUND;
          end else begin
            sticky_q <= sticky_q | mant_q[0];
            mant_q   <= mant_q >> 1;
            exp_q    <= exp_q + EXP_ONE;
            if (exp_q == EXP_ZERO) begin
              state <= S_ROUND;
            end
          end
        end

        S_ROUND: begin
          out_q       <= rnd_word;
          out_valid_q <= 1'b1;
          state       <= S_DONE;
        end

        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_normround.sv
// tb/tb_fp_div_normround.sv - self-checking bench for fp_div_normround
module tb_fp_div_normround;

  logic int_clk;
  logic reset;

  fp_div_normround_if #(.EXP_W(10), .MANT_W(27)) bus ();

  fp_div_normround #(.EXP_W(10), .MANT_W(27)) dut (
    .int_clk (int_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  initial int_clk = 1'b0;
  always #5 int_clk = ~int_clk;

  typedef struct {
    string       name;
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] mant;
    logic        sticky;
    logic [1:0]  special;
    logic [31:0] want;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(vec_t v);
    bus.in_sign    = v.sign;
    bus.in_exp     = v.exp;
    bus.in_mant    = v.mant;
    bus.in_sticky  = v.sticky;
    bus.in_special = v.special;
  endtask

  // Waits (bounded) for out_valid, sampling 1 time unit after each edge; returns edges waited.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge int_clk); #1;
      cyc++;
    end
  endtask

  task automatic run_vec(vec_t v);
    exp_t e;
    int   cyc;
    @(negedge int_clk);
    check({v.name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    drive(v);
    bus.in_valid = 1'b1;
    sb.push_back('{v.want, v.lat});
    @(posedge int_clk); #1;
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    e = sb.pop_front();
    check({v.name, " out"}, bus.Out, e.out);
    check({v.name, " latency"}, 32'(cyc), 32'(e.lat));
    @(posedge int_clk); #1;
    check({v.name, " one_cycle"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int   cyc;
    vec_t v;

    //            name           s     exp            mant           stk   spc    want           lat
    vecs.push_back('{"basic",     1'b0, 10'd127,       27'h6000000, 1'b0, 2'b00, 32'h3FC00000, 2});
    vecs.push_back('{"norm1",     1'b0, 10'd127,       27'h3000000, 1'b0, 2'b00, 32'h3F400000, 3});
    vecs.push_back('{"tie_even",  1'b0, 10'd127,       27'h4000004, 1'b0, 2'b00, 32'h3F800000, 2});
    vecs.push_back('{"tie_odd",   1'b0, 10'd127,       27'h400000C, 1'b0, 2'b00, 32'h3F800002, 2});
    vecs.push_back('{"tie_stk",   1'b0, 10'd127,       27'h4000004, 1'b1, 2'b00, 32'h3F800001, 2});
    vecs.push_back('{"ovf",       1'b1, 10'd300,       27'h4000000, 1'b0, 2'b00, 32'hFF800000, 2});
    vecs.push_back('{"ovf_rnd",   1'b0, 10'd254,       27'h7FFFFFC, 1'b0, 2'b00, 32'h7F800000, 2});
    vecs.push_back('{"max_norm",  1'b0, 10'd254,       27'h4000000, 1'b0, 2'b00, 32'h7F000000, 2});
    vecs.push_back('{"exp255",    1'b0, 10'd255,       27'h4000000, 1'b0, 2'b00, 32'h7F800000, 2});
    vecs.push_back('{"min_norm",  1'b0, 10'd1,         27'h4000000, 1'b0, 2'b00, 32'h00800000, 2});
    vecs.push_back('{"neg",       1'b1, 10'd127,       27'h6000000, 1'b0, 2'b00, 32'hBFC00000, 2});
    vecs.push_back('{"shift26",   1'b0, 10'd127,       27'h0000001, 1'b0, 2'b00, 32'h32800000, 28});
    vecs.push_back('{"mant_zero", 1'b1, 10'd127,       27'h0000000, 1'b0, 2'b00, 32'h80000000, 1});
    vecs.push_back('{"sub1",      1'b0, 10'd0,         27'h4000000, 1'b0, 2'b00, 32'h00400000, 3});
    vecs.push_back('{"sub3",      1'b0, 10'(-2),       27'h4000000, 1'b0, 2'b00, 32'h00100000, 5});
    vecs.push_back('{"sub_up",    1'b0, 10'd0,         27'h7FFFFFC, 1'b0, 2'b00, 32'h00800000, 3});
    vecs.push_back('{"sub_deep",  1'b0, 10'(-26),      27'h4000000, 1'b0, 2'b00, 32'h00000000, 29});
    vecs.push_back('{"flush27",   1'b0, 10'(-27),      27'h4000000, 1'b0, 2'b00, 32'h00000000, 3});
    vecs.push_back('{"flush40",   1'b0, 10'(-40),      27'h4000000, 1'b0, 2'b00, 32'h00000000, 3});
    vecs.push_back('{"sp_zero",   1'b1, 10'd127,       27'h6000000, 1'b0, 2'b01, 32'h80000000, 0});
    vecs.push_back('{"sp_inf",    1'b1, 10'd127,       27'h6000000, 1'b0, 2'b10, 32'hFF800000, 0});
    vecs.push_back('{"sp_nan",    1'b1, 10'd127,       27'h6000000, 1'b0, 2'b11, 32'h7FC00000, 0});

    bus.in_valid   = 1'b0;
    bus.in_sign    = 1'b0;
    bus.in_exp     = '0;
    bus.in_mant    = '0;
    bus.in_sticky  = 1'b0;
    bus.in_special = 2'b00;
    bus.out_ready  = 1'b1;
    reset          = 1'b1;
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset Out", bus.Out, 32'h0);
    repeat (3) @(negedge int_clk);
    reset = 1'b0;
    @(posedge int_clk); #1;
    check("post_reset in_ready", 32'(bus.in_ready), 32'd1);
    check("post_reset out_valid", 32'(bus.out_valid), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result and out_valid held while out_ready is low; a pending
    // input is not accepted on the retirement edge, only on the one after.
    bus.out_ready = 1'b0;
    @(negedge int_clk);
    drive(vecs[0]);
    bus.in_valid = 1'b1;
    @(posedge int_clk); #1;
    bus.in_special = 2'b11;
    wait_valid(cyc);
    check("bp latency", 32'(cyc), 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(posedge int_clk); #1;
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp Out", bus.Out, 32'h3FC00000);
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge int_clk);
    bus.out_ready = 1'b1;
    @(posedge int_clk); #1;
    check("retire out_valid", 32'(bus.out_valid), 32'd0);
    check("retire in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge int_clk); #1;
    bus.in_valid = 1'b0;
    check("next nan valid", 32'(bus.out_valid), 32'd1);
    check("next nan Out", bus.Out, 32'h7FC00000);
    @(posedge int_clk); #1;
    check("next nan retire", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a long DENORM run takes effect without a clock edge.
    v = vecs[0];
    v.exp = 10'(-20);
    @(negedge int_clk);
    drive(v);
    bus.in_valid = 1'b1;
    @(posedge int_clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge int_clk);
    #2;
    check("mid valid pre_reset", 32'(bus.out_valid), 32'd0);
    check("mid in_ready pre_reset", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("async out_valid", 32'(bus.out_valid), 32'd0);
    check("async Out", bus.Out, 32'h0);
    check("async in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge int_clk);
    reset = 1'b0;
    run_vec(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_normround.md
Name: fp_div_normround

Overview:
- Post-divide normalize/round/pack stage directly downstream of the mantissa quotient core in fp_divider.
- Accepts the raw sign, unbounded biased exponent, 27-bit quotient mantissa and sticky bit over a valid/ready handshake.
- Normalizes left one bit per cycle and denormalizes right one bit per cycle, applies round-to-nearest-even, and clamps overflow to infinity.
- Emits a packed IEEE-754 single on its own valid/ready handshake.

Parameters:
- EXP_W, 10, width of signed internal exponent (two's complement, bias 127 already applied).
- MANT_W, 27, quotient width: [26] = 2^0, [25:3] = 23 fraction bits, [2] = guard, [1:0] = round/extra.

Ports:
- int_clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  upstream result present.
- in_ready  out  1  high only in IDLE.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  signed biased exponent.
- in_mant  in  MANT_W  quotient mantissa.
- in_sticky  in  1  remainder nonzero.
- in_special  in  2  00 normal, 01 zero, 10 infinity, 11 NaN.
- out_valid  out  1  Out holds a finished result.
- out_ready  in  1  downstream accepts.
- Out  out  32  packed IEEE-754 single.

Behaviour:
- Reset:
  - Asynchronous and active-high; applies immediately, including mid-operation.
  - state=IDLE, out_valid=0, Out=0, internal registers cleared; in_ready=1 once reset is released.
- States: IDLE, NORM, DENORM, ROUND, DONE.
- IDLE:
  - Transfer occurs on in_valid&in_ready: capture sign, exp, mant, sticky.
  - in_special!=00: Out is loaded directly and the next state is DONE.
    - zero: {sign,31'h0}.
    - inf: {sign,8'hFF,23'h0}.
    - NaN: 32'h7FC00000 (sign ignored).
  - Otherwise the next state is NORM.
- NORM:
  - If mant==0: Out={sign,31'h0}, go to DONE.
  - Else if mant[26]==0: mant<<=1, exp-=1, stay in NORM (max 26 cycles).
  - Else go to DENORM if exp<1, otherwise go to ROUND.
- DENORM:
  - Flush rule, checked on the first DENORM cycle: if exp<-26, then mant=0, sticky=1, exp=1, go to ROUND.
  - Else: sticky|=mant[0], mant>>=1, exp+=1; go to ROUND once exp reaches 1.
- ROUND:
  - lsb=mant[3], guard=mant[2], rest=mant[1]|mant[0]|sticky.
  - Increment mant[26:3] by 1 when guard&(rest|lsb).
  - Carry out of bit 26: mantissa becomes 1.0, exp+=1.
  - exp>=255 after rounding: Out={sign,8'hFF,23'h0}.
  - Otherwise Out={sign, mant[26]?exp[7:0]:8'h00, mant[25:3]}; a subnormal that rounds up into bit 26 yields exponent field 1.
  - Next state: DONE.
- DONE:
  - out_valid=1; Out and out_valid are held stable while out_ready=0.
  - When out_ready=1, go to IDLE on that edge with out_valid=0.
  - in_ready=0; no new input is taken in the same cycle as output retirement.
- Latency, counted from the acceptance edge k:
  - Normalized normal input: out_valid is high after edge k+2.
  - Each left shift adds 1 cycle; each DENORM cycle adds 1 cycle; the flush path adds 1 cycle.
  - Special input: out_valid is high after edge k.
- Throughput: one operation in flight, no pipelining.
- Exponent arithmetic: signed EXP_W bits; the upstream range of -127..381 must not overflow.

Test Plan:
1. in_exp=127, in_mant=27'h6000000, sticky=0, special=00, out_ready=1 -> Out=32'h3FC00000; out_valid after edge k+2, for one cycle.
2. in_exp=127, in_mant=27'h3000000 -> one NORM shift -> Out=32'h3F400000; latency +1 cycle.
3. Round-to-nearest-even, in_exp=127:
   - in_mant=27'h4000004 -> 32'h3F800000 (tie, even, no increment).
   - in_mant=27'h400000C -> 32'h3F800002.
   - in_mant=27'h4000004 with sticky=1 -> 32'h3F800001.
4. Overflow: in_sign=1, in_exp=300, in_mant=27'h4000000 -> Out=32'hFF800000.
   - Also in_exp=254, in_mant=27'h7FFFFFC -> rounding carries out -> Out=32'h7F800000.
5. Subnormal and flush:
   - in_exp=0, in_mant=27'h4000000 -> one DENORM cycle -> Out=32'h00400000.
   - in_exp=-40 -> flush -> Out=32'h00000000.
6. Handshake, specials and reset:
   - Hold out_ready=0 for 5 cycles -> Out and out_valid stable, in_ready=0.
   - special=11 -> 32'h7FC00000 one edge after accept.
   - Assert reset mid-DENORM -> out_valid=0, Out=0 and in_ready=1 immediately, without waiting for a clock edge.
